// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one byte-masked RAM between instruction fetch and load/store.
// Builds big-endian lane masks/data for stores and zero-extends load lanes; all outputs registered.
module ram_arbiter #(
  parameter int unsigned ADDRESS_WIDTH    = 12,
  parameter bit          RESET_LAST_GRANT = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_req,
  input  logic [ADDRESS_WIDTH-1:0] fetch_address,
  output logic                     fetch_ack,
  output logic [31:0]              fetch_rdata,
  input  logic                     data_req,
  input  logic                     data_write,
  input  logic [1:0]               data_size,
  input  logic [ADDRESS_WIDTH-1:0] data_address,
  input  logic [31:0]              data_wdata,
  output logic                     data_ack,
  output logic                     data_error,
  output logic [31:0]              data_rdata,
  output logic [ADDRESS_WIDTH-1:0] ram_address,
  output logic [31:0]              ram_data_in,
  output logic [3:0]               ram_write_mask,
  output logic                     ram_write_enable,
  input  logic [31:0]              ram_data_out
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    CAPTURE,
    DONE
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  state_e state_q, state_d;
  logic   last_grant_q, last_grant_d;   // 1 = data port was granted last
  logic   grant_data_q, grant_data_d;
  logic   is_write_q, is_write_d;
  logic [1:0] size_q, size_d;
  logic [1:0] offset_q, offset_d;

  logic                     fetch_ack_q, fetch_ack_d;
  logic [31:0]              fetch_rdata_q, fetch_rdata_d;
  logic                     data_ack_q, data_ack_d;
  logic                     data_error_q, data_error_d;
  logic [31:0]              data_rdata_q, data_rdata_d;
  logic [ADDRESS_WIDTH-1:0] ram_address_q, ram_address_d;
  logic [31:0]              ram_data_in_q, ram_data_in_d;
  logic [3:0]               ram_write_mask_q, ram_write_mask_d;
  logic                     ram_write_enable_q, ram_write_enable_d;

  logic        unused_fetch_lsb;
  logic        data_illegal;
  logic        pick_data;
  logic [3:0]  store_mask;
  logic [31:0] store_data;
  logic [31:0] load_data;

  assign unused_fetch_lsb = ^fetch_address[1:0];

  assign data_illegal = (data_size == 2'd3)
                      | ((data_size == SIZE_HALF) & data_address[0])
                      | ((data_size == SIZE_WORD) & (|data_address[1:0]));

  assign pick_data = data_req & (~fetch_req | ~last_grant_q);

  // Store lanes: offset 0 is the most significant byte, mask bit 3 guards bits [31:24].
  always_comb begin
    store_mask = 4'b1111;
    store_data = data_wdata;
    case (data_size)
      SIZE_BYTE: begin
        store_mask = ~(4'b1000 >> data_address[1:0]);
        store_data = {4{data_wdata[7:0]}};
      end
      SIZE_HALF: begin
        store_mask = data_address[1] ? 4'b1100 : 4'b0011;
        store_data = {2{data_wdata[15:0]}};
      end
      SIZE_WORD: begin
        store_mask = 4'b0000;
        store_data = data_wdata;
      end
      default: begin
        store_mask = 4'b1111;
        store_data = data_wdata;
      end
    endcase
  end

  always_comb begin
    load_data = ram_data_out;
    case (size_q)
      SIZE_BYTE: begin
        case (offset_q)
          2'd0:    load_data = {24'b0, ram_data_out[31:24]};
          2'd1:    load_data = {24'b0, ram_data_out[23:16]};
          2'd2:    load_data = {24'b0, ram_data_out[15:8]};
          default: load_data = {24'b0, ram_data_out[7:0]};
        endcase
      end
      SIZE_HALF: begin
        load_data = offset_q[1] ? {16'b0, ram_data_out[15:0]}
                                : {16'b0, ram_data_out[31:16]};
      end
      default: load_data = ram_data_out;
    endcase
  end

  always_comb begin
    state_d            = state_q;
    last_grant_d       = last_grant_q;
    grant_data_d       = grant_data_q;
    is_write_d         = is_write_q;
    size_d             = size_q;
    offset_d           = offset_q;
    fetch_ack_d        = 1'b0;
    fetch_rdata_d      = fetch_rdata_q;
    data_ack_d         = 1'b0;
    data_error_d       = data_error_q;
    data_rdata_d       = data_rdata_q;
    ram_address_d      = ram_address_q;
    ram_data_in_d      = ram_data_in_q;
    ram_write_mask_d   = ram_write_mask_q;
    ram_write_enable_d = ram_write_enable_q;

    case (state_q)
      IDLE: begin
        if (fetch_req || data_req) begin
          last_grant_d = pick_data;
          grant_data_d = pick_data;
          if (pick_data) begin
            if (data_illegal) begin
              // Rejected without touching the RAM pins.
              state_d      = DONE;
              data_ack_d   = 1'b1;
              data_error_d = 1'b1;
            end else begin
              state_d       = ACCESS;
              is_write_d    = data_write;
              size_d        = data_size;
              offset_d      = data_address[1:0];
              ram_address_d = {data_address[ADDRESS_WIDTH-1:2], 2'b00};
              if (data_write) begin
                ram_data_in_d      = store_data;
                ram_write_mask_d   = store_mask;
                ram_write_enable_d = 1'b1;
              end else begin
                ram_write_mask_d   = 4'b1111;
                ram_write_enable_d = 1'b0;
              end
            end
          end else begin
            state_d            = ACCESS;
            is_write_d         = 1'b0;
            size_d             = SIZE_WORD;
            offset_d           = 2'd0;
            ram_address_d      = {fetch_address[ADDRESS_WIDTH-1:2], 2'b00};
            ram_write_mask_d   = 4'b1111;
            ram_write_enable_d = 1'b0;
          end
        end
      end

      ACCESS: begin
        // The RAM samples on the edge ending this cycle; drop the write so it lands once.
        ram_write_enable_d = 1'b0;
        ram_write_mask_d   = 4'b1111;
        if (grant_data_q && is_write_q) begin
          state_d      = DONE;
          data_ack_d   = 1'b1;
          data_error_d = 1'b0;
        end else begin
          state_d = CAPTURE;
        end
      end

      CAPTURE: begin
        ram_write_enable_d = 1'b0;
        ram_write_mask_d   = 4'b1111;
        data_error_d       = 1'b0;
        state_d            = DONE;
        if (grant_data_q) begin
          data_rdata_d = load_data;
          data_ack_d   = 1'b1;
        end else begin
          fetch_rdata_d = ram_data_out;
          fetch_ack_d   = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= IDLE;
      last_grant_q       <= RESET_LAST_GRANT;
      grant_data_q       <= 1'b0;
      is_write_q         <= 1'b0;
      size_q             <= '0;
      offset_q           <= '0;
      fetch_ack_q        <= 1'b0;
      fetch_rdata_q      <= '0;
      data_ack_q         <= 1'b0;
      data_error_q       <= 1'b0;
      data_rdata_q       <= '0;
      ram_address_q      <= '0;
      ram_data_in_q      <= '0;
      ram_write_mask_q   <= '1;
      ram_write_enable_q <= 1'b0;
    end else begin
      state_q            <= state_d;
      last_grant_q       <= last_grant_d;
      grant_data_q       <= grant_data_d;
      is_write_q         <= is_write_d;
      size_q             <= size_d;
      offset_q           <= offset_d;
      fetch_ack_q        <= fetch_ack_d;
      fetch_rdata_q      <= fetch_rdata_d;
      data_ack_q         <= data_ack_d;
      data_error_q       <= data_error_d;
      data_rdata_q       <= data_rdata_d;
      ram_address_q      <= ram_address_d;
      ram_data_in_q      <= ram_data_in_d;
      ram_write_mask_q   <= ram_write_mask_d;
      ram_write_enable_q <= ram_write_enable_d;
    end
  end

  assign fetch_ack        = fetch_ack_q;
  assign fetch_rdata      = fetch_rdata_q;
  assign data_ack         = data_ack_q;
  assign data_error       = data_error_q;
  assign data_rdata       = data_rdata_q;
  assign ram_address      = ram_address_q;
  assign ram_data_in      = ram_data_in_q;
  assign ram_write_mask   = ram_write_mask_q;
  assign ram_write_enable = ram_write_enable_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: bench-side RAM, transaction-level reference model checked every cycle,
// directed literal cases, reset-in-capture, fairness and randomized traffic.
module tb_ram_arbiter;
  localparam int unsigned AW    = 12;
  localparam int unsigned WORDS = 1 << (AW - 2);

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_req;
  logic [AW-1:0] fetch_address;
  logic          fetch_ack;
  logic [31:0]   fetch_rdata;
  logic          data_req;
  logic          data_write;
  logic [1:0]    data_size;
  logic [AW-1:0] data_address;
  logic [31:0]   data_wdata;
  logic          data_ack;
  logic          data_error;
  logic [31:0]   data_rdata;
  logic [AW-1:0] ram_address;
  logic [31:0]   ram_data_in;
  logic [3:0]    ram_write_mask;
  logic          ram_write_enable;
  logic [31:0]   ram_data_out;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDRESS_WIDTH(AW), .RESET_LAST_GRANT(1'b0)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_address(fetch_address),
    .fetch_ack(fetch_ack), .fetch_rdata(fetch_rdata),
    .data_req(data_req), .data_write(data_write), .data_size(data_size),
    .data_address(data_address), .data_wdata(data_wdata),
    .data_ack(data_ack), .data_error(data_error), .data_rdata(data_rdata),
    .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_write_mask(ram_write_mask), .ram_write_enable(ram_write_enable),
    .ram_data_out(ram_data_out)
  );

  // Bench RAM: registered read, active-low byte mask, mask bit i guards bits [8i+7:8i].
  logic [31:0] ram_mem [WORDS];
  logic [31:0] ref_mem [WORDS];
  logic [31:0] ram_w;
  always @(posedge clk) begin
    if (ram_write_enable) begin
      ram_w = ram_mem[ram_address[AW-1:2]];
      for (int i = 0; i < 4; i++)
        if (!ram_write_mask[i]) ram_w[8*i +: 8] = ram_data_in[8*i +: 8];
      ram_mem[ram_address[AW-1:2]] <= ram_w;
    end
    ram_data_out <= ram_mem[ram_address[AW-1:2]];
  end

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int          cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  // Reference model: one transaction at a time, outcome computed at grant.
  bit          model_on = 0;
  int          idle_from = 0;
  bit          pend = 0, p_data, p_err, p_read, p_store;
  int          p_ack, p_acc = -1, p_widx;
  logic [31:0] p_val, p_din;
  logic [3:0]  p_mask;
  bit          last = 0;
  logic [31:0] e_frd = '0, e_drd = '0;
  bit          e_err = 0;
  bit          m_fa, m_da, m_we, m_pd;
  int          m_k, m_nb, m_widx;
  logic [31:0] m_w, m_bsrc;
  logic [63:0] m_tmp, m_lmask;

  always @(negedge clk) begin
    if (model_on) begin
      m_fa = pend && p_ack == cyc && !p_data;
      m_da = pend && p_ack == cyc && p_data;
      m_we = pend && p_store && p_acc == cyc;
      if (m_fa) begin e_frd = p_val; e_err = 0; end
      if (m_da) begin
        if (p_read) e_drd = p_val;
        e_err = p_err;
      end
      chk("fetch_ack", {31'b0, fetch_ack}, {31'b0, m_fa});
      chk("data_ack", {31'b0, data_ack}, {31'b0, m_da});
      chk("data_error", {31'b0, data_error}, {31'b0, e_err});
      chk("fetch_rdata", fetch_rdata, e_frd);
      chk("data_rdata", data_rdata, e_drd);
      chk("ram_write_enable", {31'b0, ram_write_enable}, {31'b0, m_we});
      chk("ram_write_mask", {28'b0, ram_write_mask}, {28'b0, (m_we ? p_mask : 4'hF)});
      if (m_we) begin
        chk("ram_word_addr", {22'b0, ram_address[AW-1:2]}, p_widx);
        chk("ram_data_in", ram_data_in, p_din);
      end
      if (pend && p_ack == cyc) pend = 0;
    end
    if (reset) begin
      model_on = 1; pend = 0; idle_from = cyc + 1; last = 0;
      e_frd = '0; e_drd = '0; e_err = 0;
    end else if (model_on && cyc >= idle_from && (fetch_req || data_req)) begin
      m_pd = data_req && (!fetch_req || !last);
      last = m_pd;
      pend = 1; p_data = m_pd; p_err = 0; p_store = 0; p_read = 1; p_acc = -1;
      if (m_pd) begin
        m_k    = int'(data_address[1:0]);
        m_nb   = (data_size == 2'd0) ? 1 : (data_size == 2'd1) ? 2 : 4;
        m_widx = int'(data_address) / 4;
        p_err  = (data_size == 2'd3) || (int'(data_address) % m_nb != 0);
        if (p_err) begin
          p_read = 0; p_ack = cyc + 1;
        end else if (data_write) begin
          p_store = 1; p_read = 0; p_acc = cyc + 1; p_ack = cyc + 2;
          p_mask = 4'hF; p_widx = m_widx; m_w = ref_mem[m_widx];
          for (int lane = 0; lane < 4; lane++) begin
            m_bsrc = data_wdata >> (8 * (m_nb - 1 - (lane % m_nb)));
            p_din[8*(3-lane) +: 8] = m_bsrc[7:0];
            if (lane >= m_k && lane < m_k + m_nb) begin
              p_mask[3-lane] = 1'b0;
              m_w[8*(3-lane) +: 8] = m_bsrc[7:0];
            end
          end
          ref_mem[m_widx] = m_w;
        end else begin
          p_ack   = cyc + 3;
          m_tmp   = {32'b0, ref_mem[m_widx]} >> (8 * (4 - m_k - m_nb));
          m_lmask = (64'd1 << (8 * m_nb)) - 64'd1;
          m_tmp   = m_tmp & m_lmask;
          p_val   = m_tmp[31:0];
        end
      end else begin
        p_ack = cyc + 3;
        p_val = ref_mem[int'(fetch_address) / 4];
      end
      idle_from = p_ack + 1;
    end
    cyc++;
  end

  task automatic data_txn(input logic wr, input logic [1:0] sz, input logic [AW-1:0] a,
                          input logic [31:0] wd, output int lat, output logic [3:0] mask1,
                          output logic [31:0] rd, output logic err);
    @(posedge clk); #1;
    data_req = 1; data_write = wr; data_size = sz; data_address = a; data_wdata = wd;
    lat = 0; mask1 = 4'hF;
    @(negedge clk);
    while (!data_ack && lat < 20) begin
      @(posedge clk); #1; data_req = 0;
      @(negedge clk); lat++;
      if (lat == 1) mask1 = ram_write_mask;
    end
    data_req = 0;
    if (!data_ack) begin
      n_checks++;
      $display("FAIL data_txn_timeout addr %h: no data_ack within 20 cycles", a);
    end
    rd = data_rdata; err = data_error;
  endtask

  int          lat;
  logic [3:0]  m1;
  logic [31:0] rd, init8;
  logic        er;
  int          seq [4];
  int          cnt, guard;
  int unsigned r;

  initial begin
    for (int i = 0; i < int'(WORDS); i++) begin
      ram_mem[i] = $urandom; ref_mem[i] = ram_mem[i];
    end
    init8 = ref_mem[8];
    reset = 1; fetch_req = 0; data_req = 0; data_write = 0; data_size = 0;
    fetch_address = '0; data_address = '0; data_wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_mask", {28'b0, ram_write_mask}, 32'hF);
    chk("rst_addr", {20'b0, ram_address}, 32'h0);
    chk("rst_din", ram_data_in, 32'h0);
    chk("rst_drdata", data_rdata, 32'h0);

    data_txn(1, 2'd2, 12'h010, 32'h11223344, lat, m1, rd, er);
    chk("st_word_lat", lat, 2); chk("st_word_mask", {28'b0, m1}, 32'h0);
    data_txn(0, 2'd2, 12'h010, 32'h0, lat, m1, rd, er);
    chk("ld_word_lat", lat, 3); chk("ld_word_rd", rd, 32'h11223344);
    chk("ld_word_mask", {28'b0, m1}, 32'hF);
    data_txn(1, 2'd0, 12'h013, 32'h000000AB, lat, m1, rd, er);
    chk("st_byte_mask", {28'b0, m1}, 32'hE);
    data_txn(0, 2'd2, 12'h010, 32'h0, lat, m1, rd, er);
    chk("ld_after_byte", rd, 32'h112233AB);
    data_txn(0, 2'd0, 12'h010, 32'h0, lat, m1, rd, er);
    chk("ld_byte0", rd, 32'h00000011);
    data_txn(1, 2'd1, 12'h022, 32'h0000BEEF, lat, m1, rd, er);
    chk("st_half_mask", {28'b0, m1}, 32'hC);
    data_txn(0, 2'd1, 12'h022, 32'h0, lat, m1, rd, er);
    chk("ld_half_rd", rd, 32'h0000BEEF);
    data_txn(0, 2'd2, 12'h020, 32'h0, lat, m1, rd, er);
    chk("word20_upper", rd, {init8[31:16], 16'hBEEF});
    data_txn(1, 2'd1, 12'h021, 32'h12345678, lat, m1, rd, er);
    chk("err_half_lat", lat, 1); chk("err_half_flag", {31'b0, er}, 32'h1);
    data_txn(1, 2'd2, 12'h012, 32'h12345678, lat, m1, rd, er);
    chk("err_word_lat", lat, 1); chk("err_word_flag", {31'b0, er}, 32'h1);
    data_txn(1, 2'd3, 12'h010, 32'h12345678, lat, m1, rd, er);
    chk("err_size3_lat", lat, 1); chk("err_size3_flag", {31'b0, er}, 32'h1);
    data_txn(0, 2'd2, 12'h010, 32'h0, lat, m1, rd, er);
    chk("mem_unchanged", rd, 32'h112233AB); chk("err_cleared", {31'b0, er}, 32'h0);

    // Reset while a load sits in CAPTURE.
    @(posedge clk); #1;
    data_req = 1; data_write = 0; data_size = 2'd2; data_address = 12'h010;
    @(posedge clk); #1 data_req = 0;
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    fetch_req = 1; fetch_address = 12'h010; data_req = 1;
    @(negedge clk);
    chk("rstcap_ack", {31'b0, data_ack}, 32'h0);
    chk("rstcap_we", {31'b0, ram_write_enable}, 32'h0);
    chk("rstcap_mask", {28'b0, ram_write_mask}, 32'hF);
    chk("rstcap_rdata", data_rdata, 32'h0);

    cnt = 0; guard = 0;
    while (cnt < 4 && guard < 60) begin
      if (data_ack || fetch_ack) begin seq[cnt] = data_ack ? 1 : 0; cnt++; end
      if (cnt < 4) begin @(negedge clk); guard++; end
    end
    @(posedge clk); #1 fetch_req = 0; data_req = 0;
    if (cnt < 4) begin
      n_checks++;
      $display("FAIL fairness_timeout: %0d acks seen, 4 required", cnt);
    end else begin
      chk("grant0_data", seq[0], 1); chk("grant1_fetch", seq[1], 0);
      chk("grant2_data", seq[2], 1); chk("grant3_fetch", seq[3], 0);
      chk("fetch_rd", fetch_rdata, 32'h112233AB);
    end
    repeat (6) @(posedge clk);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      r = $urandom_range(0, 15);
      fetch_req     = ($urandom_range(0, 2) == 0);
      data_req      = ($urandom_range(0, 1) == 0);
      data_write    = ($urandom_range(0, 1) == 0);
      data_size     = (r == 0) ? 2'd3 : 2'(r % 3);
      data_address  = AW'($urandom_range(0, 63));
      fetch_address = AW'($urandom_range(0, 63));
      data_wdata    = $urandom;
    end
    @(posedge clk); #1 fetch_req = 0; data_req = 0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single on-chip byte-masked RAM between two requesters: the instruction-fetch port (read-only) and the load/store data port.
- The data port issues byte, halfword or word accesses. This block generates the active-low byte write mask, replicates store data onto the byte lanes, and extracts and zero-extends load data using big-endian lane order.
- Sits between the CPU core and the RAM. Drives the RAM's address, data_in, write_mask and write_enable pins from registers and captures the RAM's registered data_out.

Parameters:
- ADDRESS_WIDTH, 12, byte address width; matches the RAM address pin.
- RESET_LAST_GRANT, 0, round-robin pointer after reset (0 = fetch last granted, so data wins the first tie).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- fetch_req  input  1  fetch request; level, sampled only in IDLE.
- fetch_address  input  ADDRESS_WIDTH  fetch byte address; bits [1:0] ignored.
- fetch_ack  output  1  one-cycle completion pulse; fetch_rdata valid while high.
- fetch_rdata  output  32  fetched word.
- data_req  input  1  data request; level, sampled only in IDLE.
- data_write  input  1  1 = store, 0 = load.
- data_size  input  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- data_address  input  ADDRESS_WIDTH  data byte address.
- data_wdata  input  32  store data, right-justified.
- data_ack  output  1  one-cycle completion pulse.
- data_error  output  1  valid with data_ack; 1 = misaligned or illegal size, no RAM access made.
- data_rdata  output  32  load data, zero-extended.
- ram_address  output  ADDRESS_WIDTH  to RAM address.
- ram_data_in  output  32  to RAM data_in.
- ram_write_mask  output  4  to RAM write_mask, active-low per lane.
- ram_write_enable  output  1  to RAM write_enable.
- ram_data_out  input  32  from RAM; valid one clock after the address is presented with write_enable = 0.

Behaviour:
- Reset values: all acks 0, data_error 0, fetch_rdata and data_rdata 0, ram_address 0, ram_data_in 0, ram_write_mask 4'b1111, ram_write_enable 0. State is IDLE and the round-robin pointer is RESET_LAST_GRANT.
- States are IDLE, ACCESS, CAPTURE and DONE. All outputs are registered.
- IDLE: with no requests, stay in IDLE and hold RAM outputs with write_enable = 0 and mask = 4'b1111.
  - One request: grant it.
  - Both requests: grant the port not last granted, then update the pointer.
  - On grant: latch the request into the ram_* registers and the control flops.
  - Illegal data request: go directly to DONE with data_error = 1 and no RAM access.
  - Otherwise go to ACCESS.
- Illegal data request means any of:
  - size = 3;
  - half with address[0] = 1;
  - word with address[1:0] != 0.
- ACCESS: the RAM outputs are stable; the RAM samples them on the edge that ends this cycle. ram_write_enable is 1 only for a granted store. Stores go to DONE; loads and fetches go to CAPTURE.
- CAPTURE: ram_data_out is valid. Register it, with extraction for data loads, into fetch_rdata or data_rdata. Deassert ram_write_enable, set mask to 4'b1111, and go to DONE.
- DONE: the granted port's ack = 1 for exactly one cycle, then go to IDLE. A request still high in the following IDLE cycle is a new transaction.
- Latency, counted from the cycle req is seen in IDLE (cycle 0):
  - store ack in cycle 2;
  - load or fetch ack in cycle 3;
  - error ack in cycle 1.
- Throughput: one store per 3 cycles, one read per 4 cycles.
- Lane mapping (big-endian): byte offset k maps to bits [31-8k : 24-8k].
  - Byte mask: offset 0 → 0111, 1 → 1011, 2 → 1101, 3 → 1110. ram_data_in = data_wdata[7:0] replicated ×4.
  - Half mask: offset 0 → 0011, offset 2 → 1100. ram_data_in = data_wdata[15:0] replicated ×2.
  - Word mask: 0000. ram_data_in = data_wdata.
  - Loads always use mask 1111.
- Load extraction:
  - byte = {24'b0, lane k};
  - half = {16'b0, the two selected lanes};
  - word = ram_data_out unchanged.
- rdata registers hold their value until the next completed read on that port. data_error is cleared on every non-error ack.
- Inputs are not sampled outside IDLE; changes mid-transaction are ignored.
- Reset mid-transaction:
  - Return to IDLE with no ack; all outputs take their reset values after the reset edge.
  - A store in ACCESS at the reset edge may or may not commit; the addressed word is undefined and the bench must not check it.

Test Plan:
- Store word 0x11223344 to 0x010 on data, then load word 0x010 → mask 0000 during ACCESS; store ack in cycle 2; load ack in cycle 3 with data_rdata = 0x11223344.
- Store byte 0xAB at 0x013, then load word 0x010 → mask 1110; data_rdata = 0x112233AB. Load byte 0x010 → data_rdata = 0x00000011.
- Store half 0xBEEF at 0x022, then load half 0x022 → mask 1100; data_rdata = 0x0000BEEF. Upper lanes of word 0x020 are unchanged.
- Half at 0x021, word at 0x012, size = 3 → data_ack in cycle 1 with data_error = 1; ram_write_enable never asserted; memory unchanged.
- fetch_req and data_req held together continuously after reset → grants alternate data, fetch, data, fetch; each ack is a single-cycle pulse; no port starves.
- Assert reset while a load is in CAPTURE → no ack; next cycle state is IDLE, ram_write_enable = 0, mask = 1111, rdata = 0.
